// File: rtl/sign_extend_16_32.sv
// Immediate-extension unit for the single-cycle datapath.
// Widens an IN_W-bit immediate to OUT_W bits in one of four modes:
// sign, zero, upper (LUI) and sign-extend-then-shift-left-2 (branch offset).
// The combinational result feeds the datapath directly. A registered copy
// with a valid flag is kept for pipelined or debug consumers.
module sign_extend_16_32 #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  data_in_16,
    input  logic [1:0]       ext_op,
    input  logic             in_valid,
    output logic [OUT_W-1:0] data_out_32,
    output logic [OUT_W-1:0] data_out_q,
    output logic             out_valid
);

    // The branch mode drops the top two bits of the sign-extended value, so
    // the output must have at least two bits of headroom above the input.
    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("sign_extend_16_32: OUT_W must be >= IN_W + 2");
    end

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_op_e;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] branch;

    logic [OUT_W-1:0] data_d;
    logic [OUT_W-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    // Build every extension candidate, then select one by ext_op.
    always_comb begin
        sext   = {{(OUT_W - IN_W){data_in_16[IN_W-1]}}, data_in_16};
        zext   = {{(OUT_W - IN_W){1'b0}}, data_in_16};
        upper  = {data_in_16, {(OUT_W - IN_W){1'b0}}};
        branch = {sext[OUT_W-3:0], 2'b00};

        data_out_32 = sext;
        case (ext_op_e'(ext_op))
            EXT_SIGN:   data_out_32 = sext;
            EXT_ZERO:   data_out_32 = zext;
            EXT_UPPER:  data_out_32 = upper;
            EXT_BRANCH: data_out_32 = branch;
            default:    data_out_32 = sext;
        endcase
    end

    // Next state: capture the result on a valid input, otherwise hold the
    // data and drop the valid flag.
    always_comb begin
        data_d  = in_valid ? data_out_32 : data_q;
        valid_d = in_valid;
    end

    // Output register; asynchronous reset clears data and valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out_q = data_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_sign_extend_16_32.sv
// Directed testbench for sign_extend_16_32: combinational modes and
// boundaries, then the registered path including asynchronous reset.
module tb_sign_extend_16_32;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [15:0] data_in_16;
    logic [1:0]  ext_op;
    logic        in_valid;
    logic [31:0] data_out_32;
    logic [31:0] data_out_q;
    logic        out_valid;

    int unsigned tests;
    int unsigned failed;

    sign_extend_16_32 #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in_16  (data_in_16),
        .ext_op      (ext_op),
        .in_valid    (in_valid),
        .data_out_32 (data_out_32),
        .data_out_q  (data_out_q),
        .out_valid   (out_valid)
    );

    // Gated clock: stays low until the registered-path section enables it.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic comb(input logic [1:0] op, input logic [15:0] din,
                        input logic [31:0] exp, input string tag);
        ext_op     = op;
        data_in_16 = din;
        #100;
        check(tag, data_out_32, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        tests      = 0;
        failed     = 0;
        clk        = 1'b0;
        clk_en     = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        ext_op     = 2'b00;
        data_in_16 = 16'h0000;
        #1;
        check("reset_q", data_out_q, 32'h0);
        check("reset_valid", {31'b0, out_valid}, 32'h0);

        // Combinational path, no clock running.
        comb(2'b00, 16'h0000, 32'h00000000, "sign_0000");
        comb(2'b00, 16'hFFF0, 32'hFFFFFFF0, "sign_FFF0");
        comb(2'b00, 16'h000F, 32'h0000000F, "sign_000F");
        comb(2'b00, 16'h7FFF, 32'h00007FFF, "sign_7FFF");
        comb(2'b00, 16'h8000, 32'hFFFF8000, "sign_8000");
        comb(2'b00, 16'hFFFF, 32'hFFFFFFFF, "sign_FFFF");
        comb(2'b01, 16'h8000, 32'h00008000, "zero_8000");
        comb(2'b01, 16'hFFF0, 32'h0000FFF0, "zero_FFF0");
        comb(2'b01, 16'h0000, 32'h00000000, "zero_0000");
        comb(2'b10, 16'h1234, 32'h12340000, "upper_1234");
        comb(2'b10, 16'hFFFF, 32'hFFFF0000, "upper_FFFF");
        comb(2'b10, 16'h0000, 32'h00000000, "upper_0000");
        comb(2'b11, 16'h0004, 32'h00000010, "branch_0004");
        comb(2'b11, 16'hFFFF, 32'hFFFFFFFC, "branch_FFFF");
        comb(2'b11, 16'h8000, 32'hFFFE0000, "branch_8000");
        comb(2'b11, 16'h0000, 32'h00000000, "branch_0000");

        // Registered path: still in reset, no edge yet.
        check("rst_hold_q", data_out_q, 32'h0);
        check("rst_hold_valid", {31'b0, out_valid}, 32'h0);

        rst        = 1'b0;
        in_valid   = 1'b1;
        ext_op     = 2'b00;
        data_in_16 = 16'hFFF0;
        #2;
        clk_en = 1'b1;

        @(posedge clk); #1;
        check("reg_first_q", data_out_q, 32'hFFFFFFF0);
        check("reg_first_valid", {31'b0, out_valid}, 32'h1);
        in_valid   = 1'b0;
        data_in_16 = 16'h1111;

        @(posedge clk); #1;
        check("reg_idle_valid", {31'b0, out_valid}, 32'h0);
        check("reg_idle_hold_q", data_out_q, 32'hFFFFFFF0);

        // Back-to-back valid inputs.
        in_valid   = 1'b1;
        data_in_16 = 16'h0001;
        @(posedge clk); #1;
        check("b2b_0_q", data_out_q, 32'h00000001);
        check("b2b_0_valid", {31'b0, out_valid}, 32'h1);
        data_in_16 = 16'h8001;
        @(posedge clk); #1;
        check("b2b_1_q", data_out_q, 32'hFFFF8001);
        check("b2b_1_valid", {31'b0, out_valid}, 32'h1);
        data_in_16 = 16'h000F;
        @(posedge clk); #1;
        check("b2b_2_q", data_out_q, 32'h0000000F);
        check("b2b_2_valid", {31'b0, out_valid}, 32'h1);

        // Asynchronous reset between edges while out_valid is high.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", data_out_q, 32'h0);
        check("async_rst_valid", {31'b0, out_valid}, 32'h0);
        ext_op     = 2'b01;
        data_in_16 = 16'h8000;
        #1;
        check("comb_during_rst", data_out_32, 32'h00008000);

        // An edge with reset held must not capture.
        @(posedge clk); #1;
        check("rst_wins_q", data_out_q, 32'h0);
        check("rst_wins_valid", {31'b0, out_valid}, 32'h0);

        // First result after release, branch mode.
        rst        = 1'b0;
        ext_op     = 2'b11;
        data_in_16 = 16'h7FFF;
        @(posedge clk); #1;
        check("post_rst_q", data_out_q, 32'h0001FFFC);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sign_extend_16_32.md
Name: sign_extend_16_32

Overview:
Immediate-extension unit for the single-cycle CPU datapath. It widens the 16-bit instruction immediate to 32 bits for the ALU B-input, load/store address offsets, branch offsets and LUI.
- A combinational result (data_out_32) feeds the single-cycle path directly.
- A registered copy with a valid flag (data_out_q, out_valid) is provided for pipelined or debug use.

Parameters:
- IN_W, 16, input immediate width.
- OUT_W, 32, output width; must satisfy OUT_W >= IN_W + 2. Elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all register updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears the registered outputs.
- data_in_16  input  IN_W  raw immediate field (instr[15:0]).
- ext_op  input  2  extension mode: 00 sign, 01 zero, 10 upper (LUI), 11 sign-extend then shift left 2 (branch offset).
- in_valid  input  1  qualifies data_in_16/ext_op for the registered path.
- data_out_32  output  OUT_W  combinational extended result.
- data_out_q  output  OUT_W  registered extended result.
- out_valid  output  1  registered valid, aligned with data_out_q.

Behaviour:

Combinational path (data_out_32):
- Zero latency; pure function of data_in_16 and ext_op, with no dependence on clk or rst.
- ext_op=00: bits [IN_W-1:0] = data_in_16; bits [OUT_W-1:IN_W] = replicated data_in_16[IN_W-1].
- ext_op=01: bits [IN_W-1:0] = data_in_16; upper bits = 0.
- ext_op=10: {data_in_16, zeros}, i.e. data_in_16 placed in the top IN_W bits and the low OUT_W-IN_W bits = 0. For 16/32 this is data_in_16 << 16.
- ext_op=11: sign-extended value (as for 00) shifted left by 2; the two LSBs = 0 and the top 2 bits of the sign-extended value are discarded.
- When ext_op, data_in_16 or in_valid is X/Z, the output is don't-care; no X-propagation requirement.
- Default use with ext_op=00 is plain 16→32 sign extension.

Registered path (data_out_q, out_valid):
- While rst=1: data_out_q=0 and out_valid=0, immediately and independent of clk.
- On a rising clk edge with rst=0 and in_valid=1: data_out_q <= current data_out_32 and out_valid <= 1.
- On a rising clk edge with rst=0 and in_valid=0: data_out_q holds its value and out_valid <= 0.
- Latency is 1 cycle from input to data_out_q/out_valid; throughput is one result per cycle with no back-pressure.
- Reset asserted mid-stream: outputs clear at once. The first valid result after deassertion appears one edge after in_valid is sampled high.
- A rising edge that coincides with rst=1 is ignored (reset wins).

Boundaries:
- 0x7FFF → 0x00007FFF (sign).
- 0x8000 → 0xFFFF8000 (sign), 0x00008000 (zero).
- 0xFFFF → 0xFFFFFFFF (sign).
- 0x0000 → 0 in all modes.

Test Plan:
- ext_op=00, data_in_16=0x0000 then 0xFFF0 then 0x000F, 100 ns apart, no clock → data_out_32 = 0x00000000, 0xFFFFFFF0, 0x0000000F.
- ext_op=00 boundaries: 0x7FFF→0x00007FFF, 0x8000→0xFFFF8000, 0xFFFF→0xFFFFFFFF. Then ext_op=01: 0x8000→0x00008000, 0xFFF0→0x0000FFF0.
- ext_op=10: 0x1234→0x12340000, 0xFFFF→0xFFFF0000. ext_op=11: 0x0004→0x00000010, 0xFFFF→0xFFFFFFFC, 0x8000→0xFFFE0000.
- Registered path: rst=1 → data_out_q=0 and out_valid=0 with no clock edge. Release rst, in_valid=1, data_in_16=0xFFF0, ext_op=00 → after one edge data_out_q=0xFFFFFFF0 and out_valid=1. Next edge with in_valid=0 → out_valid=0 and data_out_q still 0xFFFFFFF0.
- Back-to-back valid inputs 0x0001, 0x8001, 0x000F on consecutive edges → data_out_q = 0x00000001, 0xFFFF8001, 0x0000000F on successive cycles with out_valid held at 1.
- Assert rst asynchronously between edges while out_valid=1 → data_out_q=0 and out_valid=0 immediately; data_out_32 keeps tracking its inputs throughout.
